// File: rtl/nonce_scanner.sv
// Nonce range sequencer for the double-SHA256 miner: issues nonces, expands the compact
// target and compares each returned digest against it, stopping on hit, exhaustion or abort.
module nonce_scanner (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic         cmd_abort,
  input  logic [31:0]  bits,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  output logic         miner_start,
  output logic [31:0]  miner_nonce,
  input  logic         miner_done,
  input  logic [255:0] miner_hash,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hashes_done
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StHash, StCheck, StDrain} state_e;

  state_e         state;
  logic [31:0]    cur;
  logic [31:0]    last_nonce;
  logic [255:0]   target;
  logic [255:0]   target_exp;
  logic [255:0]   hash_le;
  logic           hit;

  logic [7:0]     exp_e;
  logic [23:0]    mant;
  logic [7:0]     rsh;
  logic [7:0]     lsh;
  logic [279:0]   wide;

  // Compact-bits expansion; the 24 guard bits above 255 detect mantissa overflow.
  always_comb begin
    exp_e      = bits[31:24];
    mant       = bits[23:0];
    rsh        = '0;
    lsh        = '0;
    wide       = '0;
    target_exp = '0;
    if (mant[23] || mant == 24'd0) begin
      target_exp = '0;
    end else if (exp_e <= 8'd3) begin
      rsh        = (8'd3 - exp_e) << 3;
      target_exp = {232'd0, mant >> rsh};
    end else if (exp_e > 8'd34) begin
      target_exp = '1;
    end else begin
      lsh  = (exp_e - 8'd3) << 3;
      wide = {256'd0, mant} << lsh;
      if (wide[279:256] != 24'd0) target_exp = '1;
      else                        target_exp = wide[255:0];
    end
  end

  // Digest bytes arrive big-endian; the last byte is the most significant for the target test.
  always_comb begin
    hash_le = '0;
    for (int i = 0; i < 32; i++) begin
      hash_le[8*i +: 8] = miner_hash[8*(31-i) +: 8];
    end
  end

  assign hit  = (hash_le <= target);
  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= StIdle;
      cur         <= '0;
      last_nonce  <= '0;
      target      <= '0;
      miner_start <= 1'b0;
      miner_nonce <= '0;
      done        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hashes_done <= '0;
    end else begin
      done      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      if (cmd_abort && state != StIdle) begin
        state       <= StIdle;
        miner_start <= 1'b0;
        done        <= 1'b1;
      end else begin
        unique case (state)
          StIdle: begin
            if (cmd_start) state <= StLoad;
          end
          StLoad: begin
            cur         <= nonce_first;
            last_nonce  <= nonce_last;
            target      <= target_exp;
            hashes_done <= '0;
            found_nonce <= '0;
            found_hash  <= '0;
            miner_nonce <= nonce_first;
            miner_start <= 1'b1;
            state       <= StIssue;
          end
          StIssue: begin
            state <= StHash;
          end
          StHash: begin
            if (miner_done) state <= StCheck;
          end
          StCheck: begin
            hashes_done <= hashes_done + 32'd1;
            miner_start <= 1'b0;
            if (hit) begin
              found_nonce <= cur;
              found_hash  <= miner_hash;
              done        <= 1'b1;
              found       <= 1'b1;
              state       <= StIdle;
            end else if (cur == last_nonce) begin
              done      <= 1'b1;
              exhausted <= 1'b1;
              state     <= StIdle;
            end else begin
              cur   <= cur + 32'd1;
              state <= StDrain;
            end
          end
          StDrain: begin
            // Miner must see start low and drop done before the next nonce goes out.
            if (!miner_done) begin
              miner_nonce <= cur;
              miner_start <= 1'b1;
              state       <= StIssue;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner with a fixed-latency behavioural miner returning table hashes.
module tb_nonce_scanner;

  localparam int unsigned Lat = 3;
  localparam logic [255:0] GenHash =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_start = 1'b0;
  logic         cmd_abort = 1'b0;
  logic [31:0]  bits = '0;
  logic [31:0]  nonce_first = '0;
  logic [31:0]  nonce_last = '0;
  logic         miner_start;
  logic [31:0]  miner_nonce;
  logic         miner_done;
  logic [255:0] miner_hash;
  logic         busy;
  logic         done;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  hashes_done;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  nonce_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .bits        (bits),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .miner_start (miner_start),
    .miner_nonce (miner_nonce),
    .miner_done  (miner_done),
    .miner_hash  (miner_hash),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .hashes_done (hashes_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Miner model: done rises Lat cycles after start, hash chosen by nonce.
  logic [31:0]  hit_nonce = '0;
  logic [255:0] hit_raw = '0;
  logic [255:0] miss_raw = '1;
  logic         m_done = 1'b0;
  logic [255:0] m_hash = '0;
  int unsigned  m_cnt = 0;

  assign miner_done = m_done;
  assign miner_hash = m_hash;

  always @(posedge clk) begin
    if (!miner_start) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (!m_done) begin
      if (m_cnt == Lat - 1) begin
        m_done <= 1'b1;
        m_hash <= (miner_nonce == hit_nonce) ? hit_raw : miss_raw;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic        prev_ms = 1'b0;
  logic [31:0] issued [64];
  logic [31:0] n_issued = '0;

  always @(negedge clk) begin
    prev_ms <= miner_start;
    if (miner_start && !prev_ms) begin
      issued[n_issued[5:0]] <= miner_nonce;
      n_issued              <= n_issued + 32'd1;
    end
  end

  function automatic logic [255:0] rev256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_scan(input logic [31:0] b, input logic [31:0] f, input logic [31:0] l,
                          output bit seen, output int unsigned lat);
    int unsigned t0;
    @(negedge clk);
    bits        = b;
    nonce_first = f;
    nonce_last  = l;
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    t0   = cyc;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
  endtask

  logic [31:0]  xb [7] = '{32'h03123456, 32'h03123456, 32'h01123456, 32'h01123456,
                           32'h04923456, 32'h04923456, 32'h22123456};
  logic [255:0] xh [7] = '{256'h123456, 256'h123457, 256'h12, 256'h13, 256'h0, 256'h1,
                           {256{1'b1}}};
  logic         xf [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bit          seen;
    int unsigned lat;
    logic [31:0] base;
    logic [31:0] nz;
    int unsigned k;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ctrl", 256'({miner_start, busy, done, found, exhausted}), 256'd0);
    check_eq("rst_words", 256'({miner_nonce, found_nonce, hashes_done}), 256'd0);
    check_eq("rst_found_hash", found_hash, 256'd0);
    reset = 1'b1;

    // Genesis hit
    hit_nonce = 32'h7c2bac1d;
    hit_raw   = rev256(GenHash);
    miss_raw  = '1;
    run_scan(32'h1d00ffff, 32'h7c2bac1a, 32'h7c2bac20, seen, lat);
    check_eq("gen_done", 256'(seen), 256'd1);
    check_eq("gen_found", 256'({found, exhausted}), 256'b10);
    check_eq("gen_nonce", 256'(found_nonce), 256'h7c2bac1d);
    check_eq("gen_hashes", 256'(hashes_done), 256'd4);
    check_eq("gen_hash", rev256(found_hash), GenHash);
    @(negedge clk);
    check_eq("gen_pulse_end", 256'({done, found, exhausted, busy}), 256'd0);

    // Wrap through 0xFFFFFFFF, target 0 so every nonce misses
    hit_nonce = 32'h12345678;
    base = n_issued;
    run_scan(32'h01000000, 32'hfffffffe, 32'h00000001, seen, lat);
    check_eq("wrap_done", 256'(seen), 256'd1);
    check_eq("wrap_flags", 256'({found, exhausted}), 256'b01);
    check_eq("wrap_hashes", 256'(hashes_done), 256'd4);
    check_eq("wrap_count", 256'(n_issued - base), 256'd4);
    check_eq("wrap_n0", 256'(issued[6'(base)]), 256'hfffffffe);
    check_eq("wrap_n1", 256'(issued[6'(base + 32'd1)]), 256'hffffffff);
    check_eq("wrap_n2", 256'(issued[6'(base + 32'd2)]), 256'h0);
    check_eq("wrap_n3", 256'(issued[6'(base + 32'd3)]), 256'h1);

    // Target expansion via the hit boundary, one nonce per scan
    hit_nonce = 32'd5;
    for (int i = 0; i < 7; i++) begin
      hit_raw = rev256(xh[i]);
      run_scan(xb[i], 32'd5, 32'd5, seen, lat);
      check_eq($sformatf("exp%0d_done", i), 256'(seen), 256'd1);
      check_eq($sformatf("exp%0d_flags", i), 256'({found, exhausted}), 256'({xf[i], !xf[i]}));
    end

    // Single nonce hit latency: LOAD, ISSUE, Lat miner cycles, then HASH sample and CHECK
    hit_raw = '0;
    run_scan(32'h2100ffff, 32'd5, 32'd5, seen, lat);
    check_eq("single_done", 256'(seen), 256'd1);
    check_eq("single_found", 256'({found, exhausted}), 256'b10);
    check_eq("single_nonce", 256'(found_nonce), 256'd5);
    check_eq("single_latency", 256'(lat), 256'(Lat + 3));

    // Abort during HASH of the third nonce
    hit_nonce = 32'hffffffff;
    @(negedge clk);
    bits = 32'h01000000; nonce_first = 32'd0; nonce_last = 32'd10; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    k = 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      @(negedge clk);
      if (miner_start && !prev_ms) k++;
    end
    check_eq("abort_third_issue", 256'(k), 256'd3);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check_eq("abort_flags", 256'({done, found, exhausted}), 256'b100);
    check_eq("abort_start_busy", 256'({miner_start, busy}), 256'd0);
    check_eq("abort_hashes", 256'(hashes_done), 256'd2);
    @(negedge clk);
    check_eq("abort_pulse_end", 256'(done), 256'd0);

    // Ignored restart while busy, then reset in DRAIN
    @(negedge clk);
    bits = 32'h01000000; nonce_first = 32'd0; nonce_last = 32'd10; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    @(negedge clk);
    nonce_first = 32'd100; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    seen = 1'b0;
    nz   = '1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (miner_start && !prev_ms) begin
        seen = 1'b1;
        nz   = miner_nonce;
      end
    end
    check_eq("busy_start_ignored", 256'(nz), 256'd1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy && !miner_start) seen = 1'b1;
    end
    check_eq("drain_reached", 256'(seen), 256'd1);
    check_eq("drain_hashes", 256'(hashes_done), 256'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("midrst_ctrl", 256'({miner_start, busy, done, found, exhausted}), 256'd0);
    check_eq("midrst_words", 256'({miner_nonce, found_nonce, hashes_done}), 256'd0);
    check_eq("midrst_found_hash", found_hash, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
